// File: rtl/arm_if_pkg.sv
// Shared definitions for the instruction-fetch stage: ROM geometry, reset and
// flush constants, the IF/ID payload struct and the constant ROM image.
// No ports (package).
package arm_if_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned IMEM_DEPTH = 64;
  localparam int unsigned IMEM_AW    = 6;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t RESET_PC    = 32'h0000_0000;
  localparam word_t FLUSH_INSTR = 32'h0000_0000;

  // IF/ID pipeline register payload
  typedef struct packed {
    word_t instr;
    word_t pc_next;
    logic  valid;
  } ifid_t;

  typedef logic [IMEM_DEPTH-1:0][XLEN-1:0] rom_t;

  // Image: word k holds MOV r0,#k encoding (E3A0_0000 + k)
  function automatic rom_t build_rom();
    rom_t rom;
    for (int unsigned k = 0; k < IMEM_DEPTH; k++) begin
      rom[k] = 32'hE3A0_0000 + XLEN'(k);
    end
    return rom;
  endfunction

  localparam rom_t IMEM_INIT = build_rom();

endpackage

// File: rtl/instruction_memory.sv
// Asynchronous-read instruction ROM, 64 words, no write port.
// Ports:
//   addr     in  6   word index (pc[7:2])
//   rdata_c  out 32  combinational read data
module instruction_memory
  import arm_if_pkg::*;
(
  input  logic [IMEM_AW-1:0] addr,
  output logic [XLEN-1:0]    rdata_c
);

  assign rdata_c = IMEM_INIT[addr];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, ROM lookup and IF/ID register, with
// optional performance counters built only when IF_PERF_CNT_EN is defined.
// Ports:
//   clk           in  1   rising-edge clock
//   rst           in  1   synchronous active-high reset
//   freeze        in  1   stall request; holds PC and IF/ID
//   branch_taken  in  1   redirect PC and flush IF/ID (wins over freeze)
//   branch_addr   in  32  branch target byte address (low 2 bits dropped)
//   pc_out        out 32  PC+4 of the fetched instruction
//   instruction   out 32  fetched instruction
//   valid         out 1   real fetch (0 = bubble/flush)
//   fetch_cnt     out 32  valid IF/ID loads (0 without IF_PERF_CNT_EN)
//   stall_cnt     out 32  frozen cycles (0 without IF_PERF_CNT_EN)
module if_stage
  import arm_if_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            freeze,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_addr,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] instruction,
  output logic            valid,
  output logic [XLEN-1:0] fetch_cnt,
  output logic [XLEN-1:0] stall_cnt
);

  word_t pc;
  word_t pc_plus4_c;
  word_t rom_data_c;
  ifid_t ifid;
  logic  load_c;
  logic  hold_c;

  assign pc_plus4_c = pc + XLEN'(4);
  assign load_c     = !branch_taken && !freeze;
  assign hold_c     = !branch_taken && freeze;

  instruction_memory u_imem (
    .addr    (pc[7:2]),
    .rdata_c (rom_data_c)
  );

  // PC: branch beats freeze beats increment
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (branch_taken) begin
      pc <= branch_addr & 32'hFFFF_FFFC;
    end else if (!freeze) begin
      pc <= pc_plus4_c;
    end
  end

  // IF/ID register: flush on branch, hold on freeze, otherwise load
  always_ff @(posedge clk) begin
    if (rst || branch_taken) begin
      ifid <= '{instr: FLUSH_INSTR, pc_next: '0, valid: 1'b0};
    end else if (load_c) begin
      ifid <= '{instr: rom_data_c, pc_next: pc_plus4_c, valid: 1'b1};
    end
  end

  assign instruction = ifid.instr;
  assign pc_out      = ifid.pc_next;
  assign valid       = ifid.valid;

`ifdef IF_PERF_CNT_EN
  logic [XLEN-1:0] fetch_q;
  logic [XLEN-1:0] stall_q;

  // Every load sets valid, so each load counts as a fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_q <= '0;
      stall_q <= '0;
    end else begin
      if (load_c) fetch_q <= fetch_q + XLEN'(1);
      if (hold_c) stall_q <= stall_q + XLEN'(1);
    end
  end

  assign fetch_cnt = fetch_q;
  assign stall_cnt = stall_q;
`else
  assign fetch_cnt = '0;
  assign stall_cnt = '0;
  logic unused_hold;
  assign unused_hold = hold_c;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run
// against a behavioural fetch model. Honours IF_PERF_CNT_EN like the design.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] pc_out;
  logic [31:0] instruction;
  logic        valid;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

`ifdef IF_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_pc, m_ins, m_pco, m_fc, m_sc;
  logic        m_val;

  if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .pc_out       (pc_out),
    .instruction  (instruction),
    .valid        (valid),
    .fetch_cnt    (fetch_cnt),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_ref(input logic [31:0] a);
    return 32'hE3A0_0000 + ((a >> 2) % 32'd64);
  endfunction

  function automatic logic [31:0] cnt_exp(input logic [31:0] c);
    return PERF ? c : 32'd0;
  endfunction

  // One clock: model consumes the same inputs the DUT samples, then settle
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_pc = 0; m_ins = 0; m_pco = 0; m_val = 0; m_fc = 0; m_sc = 0;
    end else if (branch_taken) begin
      m_ins = 0; m_pco = 0; m_val = 0;
      m_pc = (branch_addr / 4) * 4;
    end else if (freeze) begin
      m_sc = m_sc + 1;
    end else begin
      m_ins = rom_ref(m_pc);
      m_pco = m_pc + 4;
      m_val = 1;
      m_pc  = m_pc + 4;
      m_fc  = m_fc + 1;
    end
    #1;
  endtask

  task automatic reset_dut();
    rst = 1; freeze = 0; branch_taken = 0; branch_addr = 0;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; freeze = 1; branch_taken = 1; branch_addr = 32'h80;
    step();
    total++; if (instruction !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=%h", instruction, 32'h0); end
    total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc_out got=%h exp=%h", pc_out, 32'h0); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    total++; if (fetch_cnt !== 32'h0 || stall_cnt !== 32'h0) begin bad++; $display("FAIL reset_cnt got=%h/%h exp=0/0", fetch_cnt, stall_cnt); end
    rst = 0; freeze = 0; branch_taken = 0;
    step();
    total++; if (instruction !== 32'hE3A0_0000 || pc_out !== 32'h4 || valid !== 1'b1) begin
      bad++; $display("FAIL reset_first_fetch got=%h/%h/%b exp=e3a00000/4/1", instruction, pc_out, valid);
    end
  endtask

  task automatic test_sequential();
    reset_dut();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL seq_valid0 got=%b exp=0", valid); end
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (instruction !== 32'hE3A0_0000 + 32'(i)) begin bad++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, instruction, 32'hE3A0_0000 + 32'(i)); end
      total++; if (pc_out !== 32'(4 * (i + 1)) || valid !== 1'b1) begin bad++; $display("FAIL seq_pc[%0d] got=%h/%b exp=%h/1", i, pc_out, valid, 32'(4 * (i + 1))); end
    end
    total++; if (fetch_cnt !== cnt_exp(32'd5)) begin bad++; $display("FAIL seq_fetch_cnt got=%0d exp=%0d", fetch_cnt, cnt_exp(32'd5)); end
  endtask

  task automatic test_freeze();
    reset_dut();
    step(); step();
    freeze = 1;
    for (int k = 1; k <= 3; k++) begin
      step();
      total++; if (instruction !== 32'hE3A0_0001 || pc_out !== 32'h8 || valid !== 1'b1) begin
        bad++; $display("FAIL freeze_hold[%0d] got=%h/%h/%b exp=e3a00001/8/1", k, instruction, pc_out, valid);
      end
      total++; if (stall_cnt !== cnt_exp(32'(k))) begin bad++; $display("FAIL freeze_stall_cnt[%0d] got=%0d exp=%0d", k, stall_cnt, cnt_exp(32'(k))); end
    end
    freeze = 0;
    step();
    total++; if (instruction !== 32'hE3A0_0002 || pc_out !== 32'hC) begin bad++; $display("FAIL freeze_resume got=%h/%h exp=e3a00002/c", instruction, pc_out); end
    total++; if (fetch_cnt !== cnt_exp(32'd3)) begin bad++; $display("FAIL freeze_fetch_cnt got=%0d exp=%0d", fetch_cnt, cnt_exp(32'd3)); end
  endtask

  task automatic test_branch();
    reset_dut();
    step(); step();
    branch_taken = 1; branch_addr = 32'h0000_0043;
    step();
    branch_taken = 0;
    total++; if (valid !== 1'b0 || instruction !== 32'h0 || pc_out !== 32'h0) begin
      bad++; $display("FAIL branch_flush got=%h/%h/%b exp=0/0/0", instruction, pc_out, valid);
    end
    step();
    total++; if (instruction !== 32'hE3A0_0010 || pc_out !== 32'h44 || valid !== 1'b1) begin
      bad++; $display("FAIL branch_target got=%h/%h/%b exp=e3a00010/44/1", instruction, pc_out, valid);
    end
  endtask

  task automatic test_branch_freeze();
    reset_dut();
    step();
    branch_taken = 1; freeze = 1; branch_addr = 32'h20;
    step();
    branch_taken = 0; freeze = 0;
    total++; if (valid !== 1'b0 || instruction !== 32'h0) begin bad++; $display("FAIL brfz_flush got=%h/%b exp=0/0", instruction, valid); end
    total++; if (stall_cnt !== 32'h0) begin bad++; $display("FAIL brfz_stall_cnt got=%0d exp=0", stall_cnt); end
    step();
    total++; if (instruction !== 32'hE3A0_0008 || pc_out !== 32'h24) begin bad++; $display("FAIL brfz_target got=%h/%h exp=e3a00008/24", instruction, pc_out); end
  endtask

  task automatic test_wrap();
    reset_dut();
    branch_taken = 1; branch_addr = 32'h0000_0100;
    step();
    branch_taken = 0;
    step();
    total++; if (instruction !== 32'hE3A0_0000 || pc_out !== 32'h104) begin bad++; $display("FAIL wrap_index got=%h/%h exp=e3a00000/104", instruction, pc_out); end
    branch_taken = 1; branch_addr = 32'hFFFF_FFFC;
    step();
    branch_taken = 0;
    step();
    total++; if (instruction !== 32'hE3A0_003F || pc_out !== 32'h0) begin bad++; $display("FAIL wrap_top got=%h/%h exp=e3a0003f/0", instruction, pc_out); end
    step();
    total++; if (instruction !== 32'hE3A0_0000 || pc_out !== 32'h4) begin bad++; $display("FAIL wrap_pc0 got=%h/%h exp=e3a00000/4", instruction, pc_out); end
  endtask

  task automatic test_reset_mid_freeze();
    reset_dut();
    for (int i = 0; i < 7; i++) step();
    total++; if (fetch_cnt !== cnt_exp(32'd7)) begin bad++; $display("FAIL rmf_fetch_cnt got=%0d exp=%0d", fetch_cnt, cnt_exp(32'd7)); end
    freeze = 1;
    step(); step();
    rst = 1;
    step();
    rst = 0; freeze = 0;
    total++; if (instruction !== 32'h0 || pc_out !== 32'h0 || valid !== 1'b0 || fetch_cnt !== 32'h0 || stall_cnt !== 32'h0) begin
      bad++; $display("FAIL rmf_zero got=%h/%h/%b/%0d/%0d exp=all 0", instruction, pc_out, valid, fetch_cnt, stall_cnt);
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int n = 0; n < 600; n++) begin
      rst          = ($urandom_range(0, 99) < 2);
      branch_taken = ($urandom_range(0, 99) < 10);
      freeze       = ($urandom_range(0, 99) < 25);
      branch_addr  = $urandom;
      step();
      total++; if (instruction !== m_ins) begin bad++; $display("FAIL rnd_instr[%0d] got=%h exp=%h", n, instruction, m_ins); end
      total++; if (pc_out !== m_pco) begin bad++; $display("FAIL rnd_pc_out[%0d] got=%h exp=%h", n, pc_out, m_pco); end
      total++; if (valid !== m_val) begin bad++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", n, valid, m_val); end
      total++; if (fetch_cnt !== cnt_exp(m_fc)) begin bad++; $display("FAIL rnd_fetch_cnt[%0d] got=%0d exp=%0d", n, fetch_cnt, cnt_exp(m_fc)); end
      total++; if (stall_cnt !== cnt_exp(m_sc)) begin bad++; $display("FAIL rnd_stall_cnt[%0d] got=%0d exp=%0d", n, stall_cnt, cnt_exp(m_sc)); end
    end
    rst = 0; branch_taken = 0; freeze = 0;
  endtask

  initial begin
    rst = 1; freeze = 0; branch_taken = 0; branch_addr = 0;
    m_pc = 0; m_ins = 0; m_pco = 0; m_val = 0; m_fc = 0; m_sc = 0;
    test_reset();
    test_sequential();
    test_freeze();
    test_branch();
    test_branch_freeze();
    test_wrap();
    test_reset_mid_freeze();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
